// File: rtl/sc_argmax_decoder.sv
// Stochastic-computing output decoder.
// Counts ones per class stream over a fixed window, then argmaxes the counts.
module sc_argmax_decoder #(
  parameter int N2      = 10,
  parameter int LOG_LEN = 8,
  parameter int CW      = LOG_LEN + 1,
  parameter int IW      = $clog2(N2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N2-1:0] din,
  input  logic          din_valid,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] class_out,
  output logic [CW-1:0] max_count,
  output logic          tie
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_ARGMAX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]      r_cnt [N2];
  logic [LOG_LEN-1:0] r_scnt;
  logic [IW-1:0]      r_k;
  logic [CW-1:0]      r_run_max;
  logic [IW-1:0]      r_run_idx;
  logic               r_run_tie;

  logic [CW-1:0] w_cur;
  logic          w_last;
  logic          w_k_end;

  assign w_cur   = r_cnt[r_k];
  assign w_last  = &r_scnt;
  assign w_k_end = (r_k == IW'(N2 - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ACCUM;
      end
      S_ACCUM: begin
        if (din_valid && w_last) w_next = S_ARGMAX;
      end
      S_ARGMAX: begin
        if (w_k_end) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N2; i++) begin
        r_cnt[i] <= '0;
      end
      r_scnt    <= '0;
      r_k       <= '0;
      r_run_max <= '0;
      r_run_idx <= '0;
      r_run_tie <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      class_out <= '0;
      max_count <= '0;
      tie       <= 1'b0;
    end else begin
      // busy stays up through DONE so it falls together with done rising
      busy <= (w_next != S_IDLE);
      done <= (r_state == S_DONE);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < N2; i++) begin
              r_cnt[i] <= '0;
            end
            r_scnt <= '0;
            r_k    <= '0;
          end
        end
        S_ACCUM: begin
          if (din_valid) begin
            for (int i = 0; i < N2; i++) begin
              r_cnt[i] <= r_cnt[i] + CW'(din[i]);
            end
            r_scnt <= r_scnt + LOG_LEN'(1);
          end
        end
        S_ARGMAX: begin
          r_k <= r_k + IW'(1);
          if (r_k == '0) begin
            r_run_max <= w_cur;
            r_run_idx <= '0;
            r_run_tie <= 1'b0;
          end else if (w_cur > r_run_max) begin
            r_run_max <= w_cur;
            r_run_idx <= r_k;
            r_run_tie <= 1'b0;
          end else if (w_cur == r_run_max) begin
            r_run_tie <= 1'b1;
          end
        end
        S_DONE: begin
          class_out <= r_run_idx;
          max_count <= r_run_max;
          tie       <= r_run_tie;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_argmax_decoder.sv
// Bench for sc_argmax_decoder: fixed vector table, random runs vs
// a ones-count model, and control-robustness sequences.
module tb_sc_argmax_decoder;

  localparam int N2      = 10;
  localparam int LOG_LEN = 8;
  localparam int CW      = LOG_LEN + 1;
  localparam int IW      = $clog2(N2);
  localparam int LEN     = 1 << LOG_LEN;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N2-1:0] din;
  logic          din_valid;
  logic          busy;
  logic          done;
  logic [IW-1:0] class_out;
  logic [CW-1:0] max_count;
  logic          tie;

  sc_argmax_decoder #(
    .N2(N2),
    .LOG_LEN(LOG_LEN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .din(din),
    .din_valid(din_valid),
    .busy(busy),
    .done(done),
    .class_out(class_out),
    .max_count(max_count),
    .tie(tie)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N2-1:0] q_din [$];
  bit            q_v   [$];

  int m_cls, m_max, m_tie, m_lat;

  typedef struct {
    string name;
    int    mode;
    bit    use_model;
    int    e_cls;
    int    e_max;
    int    e_tie;
    int    e_lat;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void push(input bit v, input logic [N2-1:0] d);
    q_v.push_back(v);
    q_din.push_back(d);
  endfunction

  function automatic void build(input int mode);
    logic [N2-1:0] d;
    int prob [N2];
    int nv;
    q_din.delete();
    q_v.delete();
    case (mode)
      0, 5, 6, 7, 8: begin
        for (int i = 0; i < LEN; i++) begin
          d = '0;
          case (mode)
            0: d[3] = 1'b1;
            5: d[4] = 1'b1;
            6: d[1] = 1'b1;
            7: d[8] = 1'b1;
            default: d[6] = 1'b1;
          endcase
          push(1'b1, d);
        end
      end
      1: begin
        for (int i = 0; i < LEN; i++) begin
          d = '0;
          d[2] = (i % 2 == 0);
          d[7] = (i < 128);
          d[5] = (i < 100);
          push(1'b1, d);
        end
      end
      2: begin
        for (int i = 0; i < LEN; i++) push(1'b1, '0);
      end
      3: begin
        for (int i = 0; i < 2 * LEN; i++) begin
          if (i % 2 == 0) begin
            push(1'b0, N2'($urandom));
          end else begin
            d = '0;
            d[9] = (i / 2 < 200);
            push(1'b1, d);
          end
        end
      end
      default: begin
        for (int i = 0; i < N2; i++) prob[i] = int'($urandom_range(0, 100));
        nv = 0;
        while (nv < LEN) begin
          if ($urandom_range(0, 4) != 0) begin
            for (int i = 0; i < N2; i++)
              d[i] = (int'($urandom_range(0, 99)) < prob[i]);
            push(1'b1, d);
            nv++;
          end else begin
            push(1'b0, N2'($urandom));
          end
        end
      end
    endcase
  endfunction

  function automatic void model();
    int cnt [N2];
    int acc;
    int pos;
    int nmax;
    acc = 0;
    pos = 0;
    foreach (cnt[i]) cnt[i] = 0;
    for (int j = 0; j < q_v.size() && acc < LEN; j++) begin
      if (q_v[j]) begin
        for (int i = 0; i < N2; i++) cnt[i] += int'(q_din[j][i]);
        acc++;
        if (acc == LEN) pos = j;
      end
    end
    m_max = 0;
    foreach (cnt[i]) if (cnt[i] > m_max) m_max = cnt[i];
    m_cls = -1;
    nmax = 0;
    foreach (cnt[i]) begin
      if (cnt[i] == m_max) begin
        nmax++;
        if (m_cls < 0) m_cls = i;
      end
    end
    m_tie = (nmax > 1) ? 1 : 0;
    m_lat = pos + N2 + 2;
  endfunction

  task automatic run_q(input bit pre_started, input int pulse_at,
                       input bit hold_next, output int lat,
                       output logic [31:0] c, output logic [31:0] m,
                       output logic [31:0] t);
    logic [IW-1:0] h_c;
    logic [CW-1:0] h_m;
    logic          h_t;
    bit            hold_ok;
    bit            busy_ok;
    bit            found;
    int            idx;
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    found   = 1'b0;
    idx     = 0;
    lat     = -1;
    c       = '0;
    m       = '0;
    t       = '0;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
    end
    h_c = class_out;
    h_m = max_count;
    h_t = tie;
    @(posedge clk);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        lat   = n;
        c     = 32'(class_out);
        m     = 32'(max_count);
        t     = 32'(tie);
        chk("busy low at done", 32'(busy), 32'd0);
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (class_out !== h_c || max_count !== h_m || tie !== h_t)
        hold_ok = 1'b0;
      start = (n == pulse_at);
      if (idx < q_v.size()) begin
        din_valid = q_v[idx];
        din       = q_din[idx];
        idx++;
      end else begin
        din_valid = 1'b0;
        din       = N2'($urandom);
      end
    end
    start     = 1'b0;
    din_valid = 1'b0;
    chk("done seen", 32'(found), 32'd1);
    chk("busy during run", 32'(busy_ok), 32'd1);
    chk("old results held", 32'(hold_ok), 32'd1);
    if (found) begin
      if (hold_next) begin
        start = 1'b1;
      end else begin
        @(negedge clk);
        chk("done one cycle", 32'(done), 32'd0);
        chk("busy after done", 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    int lat;
    logic [31:0] c, m, t;
    bit quiet;

    reset     = 1'b0;
    start     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst done", 32'(done), 32'd0);
    chk("rst class", 32'(class_out), 32'd0);
    chk("rst max", 32'(max_count), 32'd0);
    chk("rst tie", 32'(tie), 32'd0);
    chk("rst busy idle", 32'(busy), 32'd0);

    tbl.push_back('{"A_single", 0, 1'b0, 3, 256, 0, 267});
    tbl.push_back('{"B_tie", 1, 1'b0, 2, 128, 1, 267});
    tbl.push_back('{"C_zero", 2, 1'b0, 0, 0, 1, 267});
    tbl.push_back('{"D_gaps", 3, 1'b0, 9, 200, 0, 523});
    for (int r = 0; r < 5; r++)
      tbl.push_back('{"rand", 4, 1'b1, 0, 0, 0, 0});

    foreach (tbl[v]) begin
      build(tbl[v].mode);
      model();
      if (tbl[v].use_model) begin
        tbl[v].e_cls = m_cls;
        tbl[v].e_max = m_max;
        tbl[v].e_tie = m_tie;
        tbl[v].e_lat = m_lat;
      end
      run_q(1'b0, -1, 1'b0, lat, c, m, t);
      chk({tbl[v].name, " class"}, c, 32'(tbl[v].e_cls));
      chk({tbl[v].name, " max"}, m, 32'(tbl[v].e_max));
      chk({tbl[v].name, " tie"}, t, 32'(tbl[v].e_tie));
      chk({tbl[v].name, " latency"}, 32'(lat), 32'(tbl[v].e_lat));
    end

    // start pulsed mid-accumulation must be ignored
    build(5);
    run_q(1'b0, 100, 1'b0, lat, c, m, t);
    chk("E1 class", c, 32'd4);
    chk("E1 max", m, 32'd256);
    chk("E1 tie", t, 32'd0);
    chk("E1 latency", 32'(lat), 32'd267);

    // reset dropped in the middle of the argmax scan
    build(8);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 260) begin
        reset = 1'b0;
        #1;
        chk("E2 busy", 32'(busy), 32'd0);
        chk("E2 done", 32'(done), 32'd0);
        chk("E2 class", 32'(class_out), 32'd0);
        chk("E2 max", 32'(max_count), 32'd0);
        chk("E2 tie", 32'(tie), 32'd0);
        break;
      end
      din_valid = q_v[n % LEN];
      din       = q_din[n % LEN];
    end
    din_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    quiet = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("E2 idle after reset", 32'(quiet), 32'd1);

    build(4);
    model();
    run_q(1'b0, -1, 1'b0, lat, c, m, t);
    chk("E3 class", c, 32'(m_cls));
    chk("E3 max", m, 32'(m_max));
    chk("E3 tie", t, 32'(m_tie));
    chk("E3 latency", 32'(lat), 32'(m_lat));

    // back-to-back runs with start held across DONE->IDLE
    build(6);
    run_q(1'b0, -1, 1'b1, lat, c, m, t);
    chk("F1 class", c, 32'd1);
    chk("F1 max", m, 32'd256);
    build(7);
    run_q(1'b1, -1, 1'b0, lat, c, m, t);
    chk("F2 class", c, 32'd8);
    chk("F2 max", m, 32'd256);
    chk("F2 tie", t, 32'd0);
    chk("F2 latency", 32'(lat), 32'd267);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_argmax_decoder.md
# sc_argmax_decoder

Output-side decoder for the stochastic-computing MNIST classifier. It consumes the N2 class bitstreams produced by the second network layer, counts the ones in each stream over a fixed window of 2^LOG_LEN valid samples, and then runs a sequential argmax over the counts. It reports the winning class, its count and a tie flag with a one-cycle `done` pulse. It converts the unary/stochastic domain back to binary at the network boundary.

## Interface
- `N2`, 10: number of class streams.
- `LOG_LEN`, 8: log2 of stream length; the window is 2^LOG_LEN valid samples.
- `CW`, LOG_LEN+1: count width, which holds values 0..2^LOG_LEN.
- `IW`, $clog2(N2): class index width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a new decode; sampled only in IDLE.
- `din`  in  N2  one bit per class stream; bit i belongs to class i.
- `din_valid`  in  1  `din` carries a valid sample this cycle.
- `busy`  out  1  high in ACCUM and ARGMAX.
- `done`  out  1  one-cycle pulse when the result is valid.
- `class_out`  out  IW  index of the winning class.
- `max_count`  out  CW  ones-count of the winning class.
- `tie`  out  1  another class has a count equal to `max_count`.

## Operation
- Reset value is 0 for every output, every counter and the FSM state (IDLE).
- States: IDLE, ACCUM, ARGMAX, DONE.
- IDLE:
  - On `start`=1: clear all N2 ones-counters, clear the sample counter, go to ACCUM.
  - Results from the previous run are not cleared by `start`. They hold until the DONE state of the new run.
- ACCUM:
  - Each cycle with `din_valid`=1: count[i] += din[i] for every i, and the sample counter increments.
  - Cycles with `din_valid`=0 change nothing.
  - Once the sample counter has accepted 2^LOG_LEN valid samples, go to ARGMAX.
  - count[i] never exceeds 2^LOG_LEN, so no saturation logic is needed.
- ARGMAX:
  - Scans index k = 0..N2-1, one class per cycle.
  - At k=0: run_max=count[0], run_idx=0, run_tie=0.
  - At k>0 with count[k] > run_max: run_max=count[k], run_idx=k, run_tie=0.
  - At k>0 with count[k] == run_max: run_tie=1.
  - Strict comparison means the lowest index wins a tie.
  - After k=N2-1, go to DONE.
- DONE:
  - Load `class_out`/`max_count`/`tie` from run_* registers.
  - Assert `done` for this one cycle, then return to IDLE.
- Ignored inputs:
  - `start` outside IDLE is ignored, with no restart and no queuing.
  - `din`/`din_valid` outside ACCUM are ignored.
- Reset (low) in any state aborts immediately: all outputs drop to 0 and the FSM returns to IDLE. There is no partial result.

## Timing
- Every output is registered.
- `start` is high at edge S; `busy` is high from S+1.
- With `din_valid` continuously high from S+1, the last sample is accepted at edge S+2^LOG_LEN.
- ARGMAX occupies the next N2 cycles. `done`, the new results and `busy`=0 all appear at edge S+2^LOG_LEN+N2+1.
- `done` is high for exactly one cycle.
- Each `din_valid`=0 cycle in ACCUM adds one cycle to total latency.
- A `start` held high across DONE→IDLE is accepted on the first IDLE cycle, giving back-to-back runs.

## Test plan
- Run A, single winner:
  - Stimulus: LOG_LEN=8, N2=10, din[3]=1 always, other bits 0, valid continuous.
  - Response: class_out=3, max_count=256, tie=0, done exactly 267 cycles after start.
- Run B, tie:
  - Stimulus: din[2] and din[7] each high on 128 of 256 samples, din[5] high on 100, others 0.
  - Response: class_out=2, max_count=128, tie=1.
- Run C, all zero:
  - Stimulus: all-zero streams.
  - Response: class_out=0, max_count=0, tie=1. Also check done timing matches Run A.
- Run D, valid gaps:
  - Stimulus: din_valid on alternate cycles with a din[9] pattern giving 200 ones.
  - Response: class_out=9, max_count=200, done 256 cycles later than with continuous valid.
  - Garbage `din` on invalid cycles must not be counted.
- Run E, control robustness:
  - Stimulus 1: pulse `start` mid-ACCUM. Response: ignored, run completes normally.
  - Stimulus 2: drive `reset` low mid-ARGMAX. Response: all outputs 0, FSM in IDLE.
  - Stimulus 3: next run after the reset. Response: result matches a golden ones-count model.
- Run F, back-to-back:
  - Stimulus: two consecutive runs with different winners (class 1, then class 8).
  - Response: class 1 result holds until the second run's done; class_out=8 after it.
